// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_X0 = '0;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter with synchronous active-low clear; sticks at all-ones.
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Stall/bubble/flush sequencing for the 5-stage core; outputs are combinational, no added latency.
// HAZARD_PERF_CNT_EN adds saturating stall/load-use/flush cycle counters.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] IF_ID_RS1addr_i,
  input  logic [REG_AW-1:0] IF_ID_RS2addr_i,
  input  logic              ID_EX_MemRead_i,
  input  logic [REG_AW-1:0] ID_EX_RDaddr_i,
  input  logic              Branch_taken_i,
  input  logic              Mem_req_i,
  input  logic              Mem_ack_i,
  output logic              PCWrite_o,
  output logic              IF_ID_Write_o,
  output logic              NoOp_o,
  output logic              Flush_o,
  output logic              Stall_o,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0]  Stall_cnt_o,
  output logic [CNT_W-1:0]  LoadUse_cnt_o,
  output logic [CNT_W-1:0]  Flush_cnt_o,
`endif
  output logic              Timeout_err_o
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              err_d;
  logic              lu, ms, timeout, ms_eff;

  assign lu = ID_EX_MemRead_i && (ID_EX_RDaddr_i != REG_X0) &&
              ((ID_EX_RDaddr_i == IF_ID_RS1addr_i) || (ID_EX_RDaddr_i == IF_ID_RS2addr_i));
  assign ms = Mem_req_i && !Mem_ack_i;

  // On the timeout cycle the freeze is released so the pipeline gets one free cycle.
  assign timeout = (state_q == MEM_WAIT) && ms && (wcnt_q == WCNT_W'(MEM_TIMEOUT));
  assign ms_eff  = ms && !timeout;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    err_d   = Timeout_err_o;
    unique case (state_q)
      RUN: begin
        if (ms) begin
          state_d = MEM_WAIT;
          wcnt_d  = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!ms) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else if (timeout) begin
          state_d = RUN;
          wcnt_d  = '0;
          err_d   = 1'b1;
        end else begin
          wcnt_d  = wcnt_q + WCNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    PCWrite_o     = 1'b1;
    IF_ID_Write_o = 1'b1;
    NoOp_o        = 1'b0;
    Flush_o       = 1'b0;
    Stall_o       = 1'b0;
    if (rst_i) begin
      if (ms_eff) begin
        Stall_o       = 1'b1;
        PCWrite_o     = 1'b0;
        IF_ID_Write_o = 1'b0;
      end else if (lu) begin
        PCWrite_o     = 1'b0;
        IF_ID_Write_o = 1'b0;
        NoOp_o        = 1'b1;
      end else if (Branch_taken_i) begin
        Flush_o       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= RUN;
      wcnt_q        <= '0;
      Timeout_err_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      Timeout_err_o <= err_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (Stall_o),
    .cnt   (Stall_cnt_o)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_lu_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (NoOp_o),
    .cnt   (LoadUse_cnt_o)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (Flush_o),
    .cnt   (Flush_cnt_o)
  );
`endif

endmodule
